// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// hazard controller (slave): hazard sources in, register enables/flushes and counters out.
interface pipeline_hazard_controller_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 idex_mem_read_i;
  logic [4:0]           idex_rt_i;
  logic [4:0]           ifid_rs_i;
  logic [4:0]           ifid_rt_i;
  logic                 branch_taken_i;
  logic                 exmem_mem_req_i;
  logic                 mem_ready_i;

  logic                 pc_enable_o;
  logic                 ifid_enable_o;
  logic                 idex_enable_o;
  logic                 exmem_enable_o;
  logic                 ifid_flush_o;
  logic                 idex_flush_o;
  logic                 memwb_flush_o;
  logic                 mem_timeout_o;
  logic [CNT_WIDTH-1:0] stall_count_o;
  logic [CNT_WIDTH-1:0] flush_count_o;

  modport master (
    output idex_mem_read_i, idex_rt_i, ifid_rs_i, ifid_rt_i,
           branch_taken_i, exmem_mem_req_i, mem_ready_i,
    input  pc_enable_o, ifid_enable_o, idex_enable_o, exmem_enable_o,
           ifid_flush_o, idex_flush_o, memwb_flush_o, mem_timeout_o,
           stall_count_o, flush_count_o
  );

  modport slave (
    input  idex_mem_read_i, idex_rt_i, ifid_rs_i, ifid_rt_i,
           branch_taken_i, exmem_mem_req_i, mem_ready_i,
    output pc_enable_o, ifid_enable_o, idex_enable_o, exmem_enable_o,
           ifid_flush_o, idex_flush_o, memwb_flush_o, mem_timeout_o,
           stall_count_o, flush_count_o
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Five-stage pipeline hazard controller: memory-wait freeze with timeout,
// taken-branch flush, load-use bubble, and saturating stall/flush counters.
module pipeline_hazard_controller #(
  parameter int TIMEOUT   = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  pipeline_hazard_controller_if.slave   hz
);

  typedef enum logic {RUN, MEM_WAIT} state_e;

  localparam logic [7:0]           WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  state_e               state_q, state_d;
  logic [7:0]           wait_cnt_q, wait_cnt_d;
  logic                 mem_timeout_q, mem_timeout_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  logic timeout_hit;
  logic freeze;
  logic load_use;
  logic branch_flush;
  logic stall_event;

  always_comb begin
    timeout_hit  = (state_q == MEM_WAIT) && (wait_cnt_q == WAIT_LAST);
    freeze       = hz.exmem_mem_req_i && !hz.mem_ready_i && !timeout_hit;
    load_use     = hz.idex_mem_read_i && (hz.idex_rt_i != 5'd0) &&
                   ((hz.idex_rt_i == hz.ifid_rs_i) || (hz.idex_rt_i == hz.ifid_rt_i));
    // A branch seen while frozen is held in EX and only acted on at release.
    branch_flush = !freeze && hz.branch_taken_i;
    stall_event  = freeze || (load_use && !hz.branch_taken_i);
  end

  always_comb begin
    hz.pc_enable_o    = 1'b1;
    hz.ifid_enable_o  = 1'b1;
    hz.idex_enable_o  = 1'b1;
    hz.exmem_enable_o = 1'b1;
    hz.ifid_flush_o   = 1'b0;
    hz.idex_flush_o   = 1'b0;
    hz.memwb_flush_o  = 1'b0;
    if (!reset) begin
      hz.pc_enable_o    = 1'b0;
      hz.ifid_enable_o  = 1'b0;
      hz.idex_enable_o  = 1'b0;
      hz.exmem_enable_o = 1'b0;
    end else if (freeze) begin
      hz.pc_enable_o    = 1'b0;
      hz.ifid_enable_o  = 1'b0;
      hz.idex_enable_o  = 1'b0;
      hz.exmem_enable_o = 1'b0;
      hz.memwb_flush_o  = 1'b1;
    end else if (hz.branch_taken_i) begin
      hz.ifid_flush_o   = 1'b1;
      hz.idex_flush_o   = 1'b1;
    end else if (load_use) begin
      hz.pc_enable_o    = 1'b0;
      hz.ifid_enable_o  = 1'b0;
      hz.idex_flush_o   = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (freeze) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (freeze) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  always_comb begin
    mem_timeout_d = mem_timeout_q || timeout_hit;
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    if (stall_event && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (branch_flush && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      wait_cnt_q    <= 8'd0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign hz.mem_timeout_o = mem_timeout_q;
  assign hz.stall_count_o = stall_cnt_q;
  assign hz.flush_count_o = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: a default instance and a
// TIMEOUT=4 / CNT_WIDTH=2 instance share stimulus; expectations flow through a scoreboard queue.
module tb_pipeline_hazard_controller;

  localparam logic [6:0] OFF = 7'b0000000;
  localparam logic [6:0] NRM = 7'b1111000;
  localparam logic [6:0] FRZ = 7'b0000001;
  localparam logic [6:0] BRN = 7'b1111110;
  localparam logic [6:0] LDU = 7'b0011010;

  typedef struct {
    string       tag;
    bit          sel;
    logic [6:0]  ctrl;
    logic        to;
    logic [15:0] stall;
    logic [15:0] flush;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb[$];

  pipeline_hazard_controller_if #(.CNT_WIDTH(16)) bus_a ();
  pipeline_hazard_controller_if #(.CNT_WIDTH(2))  bus_b ();

  pipeline_hazard_controller #(.TIMEOUT(16), .CNT_WIDTH(16)) dut_a (
    .clk   (clk),
    .reset (reset),
    .hz    (bus_a)
  );

  pipeline_hazard_controller #(.TIMEOUT(4), .CNT_WIDTH(2)) dut_b (
    .clk   (clk),
    .reset (reset),
    .hz    (bus_b)
  );

  always #5 clk = ~clk;

  task automatic checkOutput();
    exp_t        e;
    logic [6:0]  oc;
    logic        ot;
    logic [15:0] os;
    logic [15:0] of;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty observed=0 entries required>=1");
      return;
    end
    e = sb.pop_front();
    if (e.sel) begin
      oc = {bus_b.pc_enable_o, bus_b.ifid_enable_o, bus_b.idex_enable_o, bus_b.exmem_enable_o,
            bus_b.ifid_flush_o, bus_b.idex_flush_o, bus_b.memwb_flush_o};
      ot = bus_b.mem_timeout_o;
      os = 16'(bus_b.stall_count_o);
      of = 16'(bus_b.flush_count_o);
    end else begin
      oc = {bus_a.pc_enable_o, bus_a.ifid_enable_o, bus_a.idex_enable_o, bus_a.exmem_enable_o,
            bus_a.ifid_flush_o, bus_a.idex_flush_o, bus_a.memwb_flush_o};
      ot = bus_a.mem_timeout_o;
      os = bus_a.stall_count_o;
      of = bus_a.flush_count_o;
    end
    checks++;
    assert (oc === e.ctrl) else begin
      errors++;
      $error("[TB] FAIL %s ctrl observed=%b expected=%b", e.tag, oc, e.ctrl);
    end
    checks++;
    assert (ot === e.to) else begin
      errors++;
      $error("[TB] FAIL %s mem_timeout observed=%b expected=%b", e.tag, ot, e.to);
    end
    checks++;
    assert (os === e.stall) else begin
      errors++;
      $error("[TB] FAIL %s stall_count observed=%0d expected=%0d", e.tag, os, e.stall);
    end
    checks++;
    assert (of === e.flush) else begin
      errors++;
      $error("[TB] FAIL %s flush_count observed=%0d expected=%0d", e.tag, of, e.flush);
    end
  endtask

  // Drive one cycle of inputs on both instances, queue the expectation, then sample mid-cycle.
  task automatic applyStimulus(input string tag, input bit sel, input logic rst,
                               input logic mr, input logic [4:0] rt, input logic [4:0] rs_i,
                               input logic [4:0] rt_i, input logic br, input logic req,
                               input logic rdy, input logic [6:0] ctrl, input logic to,
                               input int stall, input int flush);
    exp_t e;
    @(negedge clk);
    reset = rst;
    bus_a.idex_mem_read_i = mr;   bus_b.idex_mem_read_i = mr;
    bus_a.idex_rt_i       = rt;   bus_b.idex_rt_i       = rt;
    bus_a.ifid_rs_i       = rs_i; bus_b.ifid_rs_i       = rs_i;
    bus_a.ifid_rt_i       = rt_i; bus_b.ifid_rt_i       = rt_i;
    bus_a.branch_taken_i  = br;   bus_b.branch_taken_i  = br;
    bus_a.exmem_mem_req_i = req;  bus_b.exmem_mem_req_i = req;
    bus_a.mem_ready_i     = rdy;  bus_b.mem_ready_i     = rdy;
    e.tag   = tag;
    e.sel   = sel;
    e.ctrl  = ctrl;
    e.to    = to;
    e.stall = 16'(stall);
    e.flush = 16'(flush);
    sb.push_back(e);
    #1;
    checkOutput();
  endtask

  initial begin
    clk    = 1'b0;
    reset  = 1'b0;
    checks = 0;
    errors = 0;
    $display("[TB] starting pipeline_hazard_controller directed sequence");

    // Reset holds outputs low even with every hazard input active.
    applyStimulus("rst_hold_a",  0, 0, 1, 5, 5, 0, 1, 1, 0, OFF, 0, 0, 0);
    applyStimulus("rst_hold_b",  1, 0, 1, 5, 5, 0, 1, 1, 0, OFF, 0, 0, 0);
    applyStimulus("rst_release", 0, 1, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 0, 0);

    // Load-use detection, $zero exemption, rt match, branch priority.
    applyStimulus("load_use",    0, 1, 1, 5, 5, 0, 0, 0, 0, LDU, 0, 0, 0);
    applyStimulus("lu_bubble",   0, 1, 0, 0, 5, 0, 0, 0, 0, NRM, 0, 1, 0);
    applyStimulus("zero_reg",    0, 1, 1, 0, 0, 0, 0, 0, 0, NRM, 0, 1, 0);
    applyStimulus("zero_after",  0, 1, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 1, 0);
    applyStimulus("no_match",    0, 1, 1, 7, 3, 4, 0, 0, 0, NRM, 0, 1, 0);
    applyStimulus("lu_rt_match", 0, 1, 1, 9, 0, 9, 0, 0, 0, LDU, 0, 1, 0);
    applyStimulus("lu_rt_after", 0, 1, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 2, 0);
    applyStimulus("branch",      0, 1, 0, 0, 0, 0, 1, 0, 0, BRN, 0, 2, 0);
    applyStimulus("br_over_lu",  0, 1, 1, 5, 5, 0, 1, 0, 0, BRN, 0, 2, 1);
    applyStimulus("br_after",    0, 1, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 2, 2);
    applyStimulus("mem_rdy_run", 0, 1, 0, 0, 0, 0, 0, 1, 1, NRM, 0, 2, 2);
    applyStimulus("mem_rdy_aft", 0, 1, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 2, 2);

    // Three-cycle memory wait, then release.
    applyStimulus("rst_mem",     0, 0, 0, 0, 0, 0, 0, 0, 0, OFF, 0, 0, 0);
    applyStimulus("rel_mem",     0, 1, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 0, 0);
    applyStimulus("freeze1",     0, 1, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 0, 0);
    applyStimulus("freeze2",     0, 1, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 1, 0);
    applyStimulus("freeze3_lu",  0, 1, 1, 5, 5, 0, 0, 1, 0, FRZ, 0, 2, 0);
    applyStimulus("mem_release", 0, 1, 0, 0, 0, 0, 0, 1, 1, NRM, 0, 3, 0);
    applyStimulus("mem_done",    0, 1, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 3, 0);

    // Taken branch held during a freeze is applied only at release.
    applyStimulus("rst_br",      0, 0, 0, 0, 0, 0, 0, 0, 0, OFF, 0, 0, 0);
    applyStimulus("rel_br",      0, 1, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 0, 0);
    applyStimulus("br_frozen1",  0, 1, 0, 0, 0, 0, 1, 1, 0, FRZ, 0, 0, 0);
    applyStimulus("br_frozen2",  0, 1, 0, 0, 0, 0, 1, 1, 0, FRZ, 0, 1, 0);
    applyStimulus("br_release",  0, 1, 0, 0, 0, 0, 1, 1, 1, BRN, 0, 2, 0);
    applyStimulus("br_rel_aft",  0, 1, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 2, 1);

    // TIMEOUT=4 instance: forced release, sticky flag, reset mid-wait.
    applyStimulus("rst_to",      1, 0, 0, 0, 0, 0, 0, 0, 0, OFF, 0, 0, 0);
    applyStimulus("rel_to",      1, 1, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 0, 0);
    applyStimulus("to_freeze1",  1, 1, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 0, 0);
    applyStimulus("to_freeze2",  1, 1, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 1, 0);
    applyStimulus("to_freeze3",  1, 1, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 2, 0);
    applyStimulus("to_release",  1, 1, 0, 0, 0, 0, 0, 1, 0, NRM, 0, 3, 0);
    applyStimulus("to_sticky1",  1, 1, 0, 0, 0, 0, 0, 0, 0, NRM, 1, 3, 0);
    applyStimulus("to_sticky2",  1, 1, 0, 0, 0, 0, 0, 0, 0, NRM, 1, 3, 0);
    applyStimulus("rewait1",     1, 1, 0, 0, 0, 0, 0, 1, 0, FRZ, 1, 3, 0);
    applyStimulus("rewait2_sat", 1, 1, 0, 0, 0, 0, 0, 1, 0, FRZ, 1, 3, 0);
    applyStimulus("rst_midwait", 1, 0, 0, 0, 0, 0, 0, 1, 0, OFF, 0, 0, 0);
    applyStimulus("post_rst_f1", 1, 1, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 0, 0);
    applyStimulus("post_rst_f2", 1, 1, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 1, 0);
    applyStimulus("post_rst_f3", 1, 1, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 2, 0);
    applyStimulus("post_rst_rel",1, 1, 0, 0, 0, 0, 0, 1, 0, NRM, 0, 3, 0);
    applyStimulus("post_rst_to", 1, 1, 0, 0, 0, 0, 0, 0, 0, NRM, 1, 3, 0);

    // CNT_WIDTH=2 saturation of both counters.
    applyStimulus("rst_sat",     1, 0, 0, 0, 0, 0, 0, 0, 0, OFF, 0, 0, 0);
    applyStimulus("rel_sat",     1, 1, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus($sformatf("sat_lu%0d", i), 1, 1, 1, 5, 5, 0, 0, 0, 0, LDU, 0,
                    (i > 3) ? 3 : i, 0);
    end
    applyStimulus("sat_lu_done", 1, 1, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 3, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus($sformatf("sat_br%0d", i), 1, 1, 0, 0, 0, 0, 1, 0, 0, BRN, 0, 3,
                    (i > 3) ? 3 : i);
    end
    applyStimulus("sat_br_done", 1, 1, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 3, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
